// File: rtl/uart_pkg.sv
// Shared types for the UART transmitter: parity modes and transmit FSM states.
package uart_pkg;

  // Line parity selection as carried on cfg_parity; code 3 behaves as "none".
  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2,
    PARITY_RSVD = 2'd3
  } parity_e;

  // Transmit frame sequencer states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // True when the selected mode inserts a parity bit into the frame.
  function automatic logic parity_enabled(input parity_e mode);
    return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push is refused when full and pop
// is refused when empty. The head word is presented combinationally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         nReset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO. Frames are start, DATA_W bits LSB
// first, optional parity, then one or two stop bits, each bit lasting
// cfg_div+1 clocks. Line configuration is captured when a frame starts.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                              clk,
  input  logic                              nReset,
  input  logic [DIV_W-1:0]                  cfg_div,
  input  logic [1:0]                        cfg_parity,
  input  logic                              cfg_stop2,
  input  logic                              wr_valid,
  input  logic [DATA_W-1:0]                 wr_data,
  output logic                              wr_ready,
  input  logic                              cts,
  input  logic                              ovf_clr,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              ovf
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

  tx_state_e         state;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  baud_cnt;
  parity_e           par_mode;
  logic              stop2_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_bit;
  logic [3:0]        bit_idx;
  logic              stop_idx;
  logic              tx_q;

  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;

  logic              bit_done;
  logic              last_stop;
  logic              start_ok;
  logic              launch;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nReset    (nReset),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wr_ready  = !fifo_full;
  assign bit_done  = (baud_cnt == '0);
  assign last_stop = !stop2_q || stop_idx;
  assign start_ok  = !fifo_empty && cts;

  // A new frame begins from IDLE, or straight out of the final stop cycle so
  // that queued words leave with no idle gap between them.
  always_comb begin
    launch = 1'b0;
    if (state == IDLE) begin
      launch = start_ok;
    end else if (state == STOP && bit_done && last_stop) begin
      launch = start_ok;
    end
  end

  assign fifo_pop = launch;
  assign tx       = tx_q;
  assign busy     = (state != IDLE);

  // Sticky overflow: a refused push sets it, and a set outranks a clear.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      ovf <= 1'b0;
    end else if (wr_valid && fifo_full) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  // Frame sequencer: on launch it pops the head word and freezes the line
  // configuration, then walks the bits, reloading the baud counter per bit.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state    <= IDLE;
      tx_q     <= 1'b1;
      div_q    <= '0;
      baud_cnt <= '0;
      par_mode <= PARITY_NONE;
      stop2_q  <= 1'b0;
      shift_q  <= '0;
      par_bit  <= 1'b0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else if (launch) begin
      state    <= START;
      tx_q     <= 1'b0;
      div_q    <= cfg_div;
      baud_cnt <= cfg_div;
      par_mode <= parity_e'(cfg_parity);
      stop2_q  <= cfg_stop2;
      shift_q  <= fifo_head;
      par_bit  <= (^fifo_head) ^ (parity_e'(cfg_parity) == PARITY_ODD);
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_q <= 1'b1;
        end
        START: begin
          if (bit_done) begin
            state    <= DATA;
            tx_q     <= shift_q[0];
            shift_q  <= shift_q >> 1;
            bit_idx  <= '0;
            baud_cnt <= div_q;
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= div_q;
            if (bit_idx == LAST_BIT) begin
              if (parity_enabled(par_mode)) begin
                state <= PARITY;
                tx_q  <= par_bit;
              end else begin
                state    <= STOP;
                tx_q     <= 1'b1;
                stop_idx <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        PARITY: begin
          if (bit_done) begin
            state    <= STOP;
            tx_q     <= 1'b1;
            stop_idx <= 1'b0;
            baud_cnt <= div_q;
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (bit_done) begin
            if (last_stop) begin
              state <= IDLE;
            end else begin
              stop_idx <= 1'b1;
              baud_cnt <= div_q;
            end
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo. Expected line waveforms come from a
// frame model that lists the bits of each frame and stretches each one by
// the bit period; a second instance with 7 data bits shares the clock.
module tb_uart_tx_fifo;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int DIV_W      = 16;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  logic              clk = 1'b0;
  logic              nReset;
  logic [DIV_W-1:0]  cfg_div;
  logic [1:0]        cfg_parity;
  logic              cfg_stop2;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              cts;
  logic              ovf_clr;
  logic              tx;
  logic              busy;
  logic [CNT_W-1:0]  fifo_count;
  logic              ovf;

  logic              wr_valid7;
  logic [6:0]        wr_data7;
  logic              wr_ready7;
  logic              tx7;
  logic              busy7;
  logic [CNT_W-1:0]  fifo_count7;
  logic              ovf7;

  int checks = 0;
  int errors = 0;

  bit exp_tx[$];
  bit exp_busy[$];
  bit obs_tx[$];
  bit obs_busy[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .nReset(nReset), .cfg_div(cfg_div), .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .cts(cts), .ovf_clr(ovf_clr), .tx(tx), .busy(busy),
    .fifo_count(fifo_count), .ovf(ovf)
  );

  uart_tx_fifo #(.DATA_W(7), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut7 (
    .clk(clk), .nReset(nReset), .cfg_div(cfg_div), .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2), .wr_valid(wr_valid7), .wr_data(wr_data7),
    .wr_ready(wr_ready7), .cts(cts), .ovf_clr(ovf_clr), .tx(tx7), .busy(busy7),
    .fifo_count(fifo_count7), .ovf(ovf7)
  );

  // Reference model: expected per-cycle line level and busy for one frame.
  function automatic void model_frame(input logic [8:0] data, input int dw,
                                      input int div, input int par, input bit stop2);
    bit bits[$];
    int ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < dw; i++) begin
      bits.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (par == 1) bits.push_back(bit'(ones % 2));
    if (par == 2) bits.push_back(bit'(1 - ones % 2));
    bits.push_back(1'b1);
    if (stop2) bits.push_back(1'b1);
    foreach (bits[b]) begin
      repeat (div + 1) begin
        exp_tx.push_back(bits[b]);
        exp_busy.push_back(1'b1);
      end
    end
  endfunction

  function automatic void model_idle(input int n);
    repeat (n) begin
      exp_tx.push_back(1'b1);
      exp_busy.push_back(1'b0);
    end
  endfunction

  function automatic void model_clear();
    exp_tx.delete();
    exp_busy.delete();
  endfunction

  function automatic int first_diff(input bit sel_busy);
    for (int i = 0; i < exp_tx.size(); i++) begin
      if (i >= obs_tx.size()) return i;
      if (sel_busy ? (obs_busy[i] != exp_busy[i]) : (obs_tx[i] != exp_tx[i])) return i;
    end
    return -1;
  endfunction

  function automatic int busy_cycles();
    int n = 0;
    foreach (obs_busy[i]) n += int'(obs_busy[i]);
    return n;
  endfunction

  task automatic do_reset();
    nReset = 1'b0; wr_valid = 1'b0; wr_valid7 = 1'b0; wr_data = '0; wr_data7 = '0;
    cts = 1'b0; ovf_clr = 1'b0; cfg_div = '0; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    repeat (2) @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_word(input logic [8:0] d, input int which);
    if (which == 0) begin wr_valid = 1'b1; wr_data = d[DATA_W-1:0]; end
    else begin wr_valid7 = 1'b1; wr_data7 = d[6:0]; end
    @(negedge clk);
    wr_valid = 1'b0; wr_valid7 = 1'b0;
  endtask

  // Waits for the line to fall, then records exp_tx.size() samples from there.
  // At sample drop_at, cts is withdrawn and the line configuration is altered.
  task automatic capture(input int which, input int max_wait, input int drop_at, output bit found);
    obs_tx.delete(); obs_busy.delete(); found = 1'b0;
    for (int i = 0; i < max_wait && !found; i++) begin
      @(negedge clk);
      if (((which != 0) ? tx7 : tx) == 1'b0) found = 1'b1;
    end
    if (found) begin
      for (int k = 0; k < exp_tx.size(); k++) begin
        if (k > 0) @(negedge clk);
        if (k == drop_at) begin cts = 1'b0; cfg_div = 16'd2; cfg_parity = 2'd2; end
        obs_tx.push_back((which != 0) ? tx7 : tx);
        obs_busy.push_back((which != 0) ? busy7 : busy);
      end
    end
  endtask

  task automatic wait_idle(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles && !ok; i++) begin
      @(negedge clk);
      if (!busy && fifo_count == 0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %0b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (fifo_count !== '0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %0b expected 0", ovf); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_wr_ready: got %0b expected 1", wr_ready); end
    checks++; if (tx7 !== 1'b1 || busy7 !== 1'b0) begin errors++; $display("[TB] FAIL reset_dut7: tx=%0b busy=%0b expected 1/0", tx7, busy7); end
  endtask

  task automatic test_basic_frame(input int which);
    int dw;
    int d;
    bit found;
    dw = (which != 0) ? 7 : 8;
    do_reset();
    cfg_div = 16'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0; cts = 1'b1;
    model_clear(); model_frame(9'h055, dw, 3, 0, 1'b0); model_idle(4);
    push_word(9'h055, which);
    capture(which, 20, -1, found);
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL basic_start_dw%0d: no start bit seen expected one", dw); end
    else begin
      d = first_diff(1'b0);
      if (d != -1) begin errors++; $display("[TB] FAIL basic_tx_dw%0d: cycle %0d got %0b expected %0b", dw, d, obs_tx[d], exp_tx[d]); end
      checks++;
      if (busy_cycles() !== (dw + 2) * 4) begin errors++; $display("[TB] FAIL basic_busy_len_dw%0d: got %0d expected %0d", dw, busy_cycles(), (dw + 2) * 4); end
      checks++;
      d = first_diff(1'b1);
      if (d != -1) begin errors++; $display("[TB] FAIL basic_busy_dw%0d: cycle %0d got %0b expected %0b", dw, d, obs_busy[d], exp_busy[d]); end
    end
  endtask

  task automatic test_parity();
    int d;
    bit found;
    for (int p = 1; p <= 2; p++) begin
      do_reset();
      cfg_div = '0; cfg_parity = 2'(p); cfg_stop2 = 1'b0; cts = 1'b1;
      model_clear(); model_frame(9'h007, 8, 0, p, 1'b0); model_idle(3);
      push_word(9'h007, 0);
      capture(0, 20, -1, found);
      checks++;
      if (!found) begin errors++; $display("[TB] FAIL parity%0d_start: no start bit seen expected one", p); end
      else begin
        d = first_diff(1'b0);
        if (d != -1) begin errors++; $display("[TB] FAIL parity%0d_tx: cycle %0d got %0b expected %0b", p, d, obs_tx[d], exp_tx[d]); end
        checks++;
        if (obs_tx[9] !== ((p == 1) ? 1'b1 : 1'b0)) begin errors++; $display("[TB] FAIL parity%0d_bit: got %0b expected %0b", p, obs_tx[9], (p == 1) ? 1'b1 : 1'b0); end
        checks++;
        if (busy_cycles() !== 11) begin errors++; $display("[TB] FAIL parity%0d_len: got %0d expected 11", p, busy_cycles()); end
      end
    end
  endtask

  task automatic test_overflow();
    logic [8:0] words[9];
    bit line_moved;
    bit found;
    int d;
    do_reset();
    line_moved = 1'b0;
    for (int i = 0; i < 9; i++) begin
      words[i] = 9'($urandom_range(0, 255));
      wr_valid = 1'b1; wr_data = words[i][7:0];
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) line_moved = 1'b1;
      if (i == 6) begin
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL ovf_ready_at7: got %0b expected 1", wr_ready); end
      end
      if (i == 7) begin
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL ovf_ready_at8: got %0b expected 0", wr_ready); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early: got %0b expected 0", ovf); end
      end
    end
    wr_valid = 1'b0;
    checks++; if (fifo_count !== CNT_W'(8)) begin errors++; $display("[TB] FAIL ovf_count: got %0d expected 8", fifo_count); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %0b expected 1", ovf); end
    checks++; if (line_moved) begin errors++; $display("[TB] FAIL ovf_line_idle: got activity expected tx=1 busy=0"); end
    wr_valid = 1'b1; ovf_clr = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set_wins: got %0b expected 1", ovf); end
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %0b expected 0", ovf); end
    model_clear();
    for (int i = 0; i < 8; i++) model_frame(words[i], 8, 0, 0, 1'b0);
    model_idle(4);
    cts = 1'b1;
    capture(0, 10, -1, found);
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL ovf_drain_start: no start bit seen expected one"); end
    else begin
      d = first_diff(1'b0);
      if (d != -1) begin errors++; $display("[TB] FAIL ovf_drain_tx: cycle %0d got %0b expected %0b", d, obs_tx[d], exp_tx[d]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] w0, w1;
    bit found;
    int d;
    do_reset();
    cfg_div = 16'd1; cfg_parity = 2'd1; cfg_stop2 = 1'b1;
    w0 = 9'($urandom_range(0, 255)); w1 = 9'($urandom_range(0, 255));
    push_word(w0, 0); push_word(w1, 0);
    checks++; if (fifo_count !== CNT_W'(2)) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 2", fifo_count); end
    model_clear(); model_frame(w0, 8, 1, 1, 1'b1); model_frame(w1, 8, 1, 1, 1'b1); model_idle(4);
    cts = 1'b1;
    capture(0, 10, -1, found);
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL b2b_start: no start bit seen expected one"); end
    else begin
      d = first_diff(1'b0);
      if (d != -1) begin errors++; $display("[TB] FAIL b2b_tx: cycle %0d got %0b expected %0b", d, obs_tx[d], exp_tx[d]); end
      checks++;
      d = first_diff(1'b1);
      if (d != -1) begin errors++; $display("[TB] FAIL b2b_busy: cycle %0d got %0b expected %0b", d, obs_busy[d], exp_busy[d]); end
    end
  endtask

  task automatic test_push_pop();
    bit ok;
    do_reset();
    cfg_div = 16'd1;
    push_word(9'h0A5, 0);
    cts = 1'b1; wr_valid = 1'b1; wr_data = 8'h3C;
    @(negedge clk);
    wr_valid = 1'b0;
    checks++; if (fifo_count !== CNT_W'(1)) begin errors++; $display("[TB] FAIL push_pop_count: got %0d expected 1", fifo_count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL push_pop_busy: got %0b expected 1", busy); end
    wait_idle(200, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL push_pop_drain: got timeout expected idle"); end
  endtask

  task automatic test_cts_mid();
    logic [8:0] w0, w1;
    bit found;
    int d;
    do_reset();
    cfg_div = 16'd1; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    w0 = 9'($urandom_range(0, 255)); w1 = 9'($urandom_range(0, 255));
    push_word(w0, 0); push_word(w1, 0);
    model_clear(); model_frame(w0, 8, 1, 0, 1'b0); model_idle(12);
    cts = 1'b1;
    capture(0, 10, 8, found);
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL cts_mid_start: no start bit seen expected one"); end
    else begin
      d = first_diff(1'b0);
      if (d != -1) begin errors++; $display("[TB] FAIL cts_mid_tx: cycle %0d got %0b expected %0b", d, obs_tx[d], exp_tx[d]); end
      checks++;
      d = first_diff(1'b1);
      if (d != -1) begin errors++; $display("[TB] FAIL cts_mid_hold: cycle %0d busy got %0b expected %0b", d, obs_busy[d], exp_busy[d]); end
    end
    model_clear(); model_frame(w1, 8, 2, 2, 1'b0); model_idle(3);
    cts = 1'b1;
    capture(0, 10, -1, found);
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL cts_resume_start: no start bit seen expected one"); end
    else begin
      d = first_diff(1'b0);
      if (d != -1) begin errors++; $display("[TB] FAIL cts_resume_tx: cycle %0d got %0b expected %0b", d, obs_tx[d], exp_tx[d]); end
    end
  endtask

  task automatic test_random();
    logic [8:0] w;
    int n, div, par;
    bit st2, found;
    int d;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      n = $urandom_range(1, 3); div = $urandom_range(0, 3);
      par = $urandom_range(0, 3); st2 = 1'($urandom_range(0, 1));
      cfg_div = DIV_W'(div); cfg_parity = 2'(par); cfg_stop2 = st2;
      model_clear();
      for (int k = 0; k < n; k++) begin
        w = 9'($urandom_range(0, 255));
        model_frame(w, 8, div, par, st2);
        push_word(w, 0);
      end
      model_idle(3);
      checks++; if (fifo_count !== CNT_W'(n)) begin errors++; $display("[TB] FAIL rand%0d_count: got %0d expected %0d", it, fifo_count, n); end
      cts = 1'b1;
      capture(0, 10, -1, found);
      checks++;
      if (!found) begin errors++; $display("[TB] FAIL rand%0d_start: no start bit seen expected one", it); end
      else begin
        d = first_diff(1'b0);
        if (d != -1) begin errors++; $display("[TB] FAIL rand%0d_tx: cycle %0d got %0b expected %0b (div %0d par %0d stop2 %0b)", it, d, obs_tx[d], exp_tx[d], div, par, st2); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    bit line_moved;
    do_reset();
    cfg_div = 16'd2; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    push_word(9'h0F0, 0); push_word(9'h011, 0); push_word(9'h022, 0);
    cts = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (tx == 1'b0) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL rst_mid_start: no start bit seen expected one"); end
    repeat (4) @(negedge clk);
    nReset = 1'b0;
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_tx: got %0b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy: got %0b expected 0", busy); end
    checks++; if (fifo_count !== '0) begin errors++; $display("[TB] FAIL rst_mid_count: got %0d expected 0", fifo_count); end
    nReset = 1'b1;
    line_moved = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) line_moved = 1'b1;
    end
    checks++; if (line_moved) begin errors++; $display("[TB] FAIL rst_mid_discard: got activity expected idle line"); end
  endtask

  initial begin
    test_reset();
    test_basic_frame(0);
    test_basic_frame(1);
    test_parity();
    test_overflow();
    test_back_to_back();
    test_push_pop();
    test_cts_mid();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
